apb3_slv_bridge: RTL and testbench
==================================

// Module: apb3_slv_bridge
// PURPOSE
//  APB3 slave front-end that converts each APB transfer into a native single-beat request
//  (if_req_vld pulse, if_wr_en/if_rd_en, if_addr, if_wr_data) for the downstream slave FSM.
//  It waits for that FSM's if_ack_vld/if_rd_data/if_err and returns pready/prdata/pslverr.
//  An optional ack timeout completes a hung transfer with an error and soft-resets the FSM.
// PARAMETERS
//  ADDR_WIDTH      32  paddr / if_addr width
//  DATA_WIDTH      32  pwdata / prdata / if_wr_data / if_rd_data width
//  TIMEOUT_CYCLES  0   max WAIT_ACK cycles before error completion; 0 = timeout disabled
// PORTS
//  clk          in   1           clock
//  rst_n        in   1           asynchronous reset, active-low
//  psel         in   1           APB select
//  penable      in   1           APB enable (access phase)
//  pwrite       in   1           APB direction: 1 = write
//  paddr        in   ADDR_WIDTH  APB address
//  pwdata       in   DATA_WIDTH  APB write data
//  pready       out  1           transfer complete, registered
//  prdata       out  DATA_WIDTH  read data, valid only while pready=1, else 0
//  pslverr      out  1           error, valid only while pready=1, else 0
//  soft_rst     in   1           synchronous soft reset from the register block
//  if_soft_rst  out  1           soft reset to the slave FSM = soft_rst | to_pulse
//  if_req_vld   out  1           one-cycle request pulse
//  if_wr_en     out  1           write request, held from capture until return to IDLE
//  if_rd_en     out  1           read request, held from capture until return to IDLE
//  if_addr      out  ADDR_WIDTH  captured paddr
//  if_wr_data   out  DATA_WIDTH  captured pwdata
//  if_ack_vld   in   1           slave FSM ack
//  if_rd_data   in   DATA_WIDTH  slave FSM read data, qualified by if_ack_vld
//  if_err       in   1           slave FSM error, qualified by if_ack_vld
// BEHAVIOUR
//  Reset: state=IDLE. All registered outputs are 0: pready, prdata, pslverr, if_req_vld,
//    if_wr_en, if_rd_en, if_addr, if_wr_data, to_pulse. if_soft_rst follows soft_rst.
//  FSM states: IDLE, REQ, WAIT_ACK, RESP.
//  IDLE: when psel=1 and penable=0 (setup phase), capture paddr/pwdata into if_addr/if_wr_data.
//    Set if_wr_en=pwrite and if_rd_en=!pwrite. Go to REQ. Other inputs: stay in IDLE.
//  REQ: one cycle. if_req_vld = (state==REQ) & !soft_rst. Next state is WAIT_ACK,
//    or RESP with pslverr=1 and prdata=0 if soft_rst=1.
//  WAIT_ACK: if_ack_vld=1 -> register prdata = read ? if_rd_data : 0 and pslverr = if_err;
//    go to RESP. soft_rst=1 (takes priority over ack) -> RESP with error, prdata=0.
//    Timeout counter (width $clog2(TIMEOUT_CYCLES+1)) clears on entry and increments each
//    cycle without ack. At count==TIMEOUT_CYCLES-1 with no ack -> RESP with error, prdata=0.
//    Also set to_pulse=1 for exactly the first RESP cycle.
//  RESP: pready=1 for exactly one cycle. Clear if_wr_en/if_rd_en. Go to IDLE.
//    Next cycle: pready, prdata and pslverr return to 0.
//  Latency: setup at cycle T, if_req_vld at T+1, earliest ack at T+2, pready at T+3
//    (2 wait states minimum). Each further ack delay cycle adds one wait state.
//  if_ack_vld outside WAIT_ACK (e.g. a late ack after timeout) is ignored.
//  psel drop mid-transfer (protocol violation): the transfer completes internally and RESP
//    still lasts one cycle. No hang and no retry.
//  Back-to-back: a setup phase in the cycle after RESP is captured normally (bridge in IDLE).
//  Only one transfer is outstanding at a time. No pipelining and no buffering beyond the capture regs.
// STRUCTURE
//  Package apb3_slv_bridge_pkg: state enum typedef (2-bit: IDLE, REQ, WAIT_ACK, RESP).
//  Sub-module slv_ack_timer: load/enable counter with expiry flag, param TIMEOUT_CYCLES,
//    tied off when TIMEOUT_CYCLES=0.
//  Top level: FSM, capture regs, response regs, if_soft_rst OR gate.
// TESTING
//  1. Write paddr=0x10, pwdata=0xA5A5_0001, ack at T+2, if_err=0 -> if_req_vld at T+1 only;
//     if_wr_en=1 and if_addr=0x10; pready at T+3 with pslverr=0.
//  2. Read, ack 5 cycles after req with if_rd_data=0xDEAD_BEEF -> pready at T+7 with
//     prdata=0xDEAD_BEEF; prdata=0 the following cycle.
//  3. Read, ack with if_err=1 and if_rd_data=0 -> pready=1, pslverr=1, prdata=0.
//  4. TIMEOUT_CYCLES=4, no ack -> pready at T+6 with pslverr=1; if_soft_rst high that cycle only;
//     late ack at T+7 ignored and the FSM stays in IDLE.
//  5. soft_rst in the REQ cycle -> no if_req_vld; pready next cycle with pslverr=1.
//     soft_rst in WAIT_ACK concurrent with ack -> pslverr=1.
//  6. Two back-to-back writes, setup immediately after first pready, plus async rst_n
//     mid-WAIT_ACK -> second transfer correct; after reset all outputs 0 and state IDLE.

Source files
------------

// File: rtl/apb3_slv_bridge_pkg.sv
// Shared types for the APB3 slave bridge.
//   state_e : bridge FSM state encoding (IDLE, REQ, WAIT_ACK, RESP)
package apb3_slv_bridge_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StWaitAck = 2'd2,
    StResp    = 2'd3
  } state_e;

endpackage

// File: rtl/slv_ack_timer.sv
// Ack timeout counter for the APB3 slave bridge.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : clear the count (asserted in the cycle before WAIT_ACK is entered)
//   enable     : count this cycle (WAIT_ACK with no ack)
//   expired    : this is the last permitted wait cycle with no ack
// TIMEOUT_CYCLES = 0 disables the timer; expired is then tied low.
module slv_ack_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic enable,
  output logic expired
);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst_n, load, enable};
    assign expired       = 1'b0;
  end else begin : g_on
    localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(TIMEOUT_CYCLES - 1);

    logic [CntWidth-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (load) begin
        cnt_q <= '0;
      end else if (enable) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign expired = enable && (cnt_q == CntLast);
  end

endmodule

// File: rtl/apb3_slv_bridge.sv
// APB3 slave front-end: turns each APB transfer into a single-beat native request for the
// downstream slave FSM and returns its ack as pready/prdata/pslverr.
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   psel/penable/pwrite/paddr/pwdata : APB request
//   pready/prdata/pslverr            : APB response, registered, zero outside the RESP cycle
//   soft_rst                         : synchronous soft reset from the register block
//   if_soft_rst                      : soft reset to the slave FSM (soft_rst or ack timeout)
//   if_req_vld/if_wr_en/if_rd_en     : request pulse and held direction
//   if_addr/if_wr_data               : captured address and write data
//   if_ack_vld/if_rd_data/if_err     : slave FSM completion
module apb3_slv_bridge
  import apb3_slv_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic                  pready,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pslverr,
  input  logic                  soft_rst,
  output logic                  if_soft_rst,
  output logic                  if_req_vld,
  output logic                  if_wr_en,
  output logic                  if_rd_en,
  output logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_wr_data,
  input  logic                  if_ack_vld,
  input  logic [DATA_WIDTH-1:0] if_rd_data,
  input  logic                  if_err
);

  state_e                state_q, state_d;
  logic                  pready_q;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  pslverr_q, pslverr_d;
  logic                  to_pulse_q, to_pulse_d;
  logic                  wr_en_q, rd_en_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  capture;
  logic                  to_expired;

  // Only a setup phase seen in IDLE starts a transfer.
  assign capture = (state_q == StIdle) && psel && !penable;

  slv_ack_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_ack_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (state_q == StReq),
    .enable ((state_q == StWaitAck) && !if_ack_vld),
    .expired(to_expired)
  );

  // Response values are only non-zero on the transition into RESP, so the
  // registered outputs drop back to 0 automatically after one cycle.
  always_comb begin
    state_d    = state_q;
    prdata_d   = '0;
    pslverr_d  = 1'b0;
    to_pulse_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (capture) state_d = StReq;
      end
      StReq: begin
        if (soft_rst) begin
          state_d   = StResp;
          pslverr_d = 1'b1;
        end else begin
          state_d = StWaitAck;
        end
      end
      StWaitAck: begin
        if (soft_rst) begin
          state_d   = StResp;
          pslverr_d = 1'b1;
        end else if (if_ack_vld) begin
          state_d   = StResp;
          pslverr_d = if_err;
          prdata_d  = rd_en_q ? if_rd_data : '0;
        end else if (to_expired) begin
          state_d    = StResp;
          pslverr_d  = 1'b1;
          to_pulse_d = 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pready_q   <= 1'b0;
      prdata_q   <= '0;
      pslverr_q  <= 1'b0;
      to_pulse_q <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      pready_q   <= (state_d == StResp);
      prdata_q   <= prdata_d;
      pslverr_q  <= pslverr_d;
      to_pulse_q <= to_pulse_d;
      if (capture) begin
        addr_q  <= paddr;
        wdata_q <= pwdata;
        wr_en_q <= pwrite;
        rd_en_q <= !pwrite;
      end else if (state_q == StResp) begin
        wr_en_q <= 1'b0;
        rd_en_q <= 1'b0;
      end
    end
  end

  assign pready      = pready_q;
  assign prdata      = prdata_q;
  assign pslverr     = pslverr_q;
  assign if_req_vld  = (state_q == StReq) && !soft_rst;
  assign if_wr_en    = wr_en_q;
  assign if_rd_en    = rd_en_q;
  assign if_addr     = addr_q;
  assign if_wr_data  = wdata_q;
  assign if_soft_rst = soft_rst | to_pulse_q;

endmodule

// File: tb/tb_apb3_slv_bridge.sv
// Self-checking bench for apb3_slv_bridge. Instance dut_a has the timeout disabled and runs
// the per-cycle vector table; dut_b (TIMEOUT_CYCLES=4) shares the same stimulus and is
// checked in the timeout sequence. Each table row drives inputs for one cycle and gives the
// outputs expected in that same cycle.
module tb_apb3_slv_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite, soft_rst;
  logic [31:0] paddr, pwdata;
  logic        if_ack_vld, if_err;
  logic [31:0] if_rd_data;

  logic        pready_a, pslverr_a, isr_a, req_a, wen_a, ren_a;
  logic [31:0] prdata_a, addr_a, wd_a;
  logic        pready_b, pslverr_b, isr_b, req_b, wen_b, ren_b;
  logic [31:0] prdata_b, addr_b, wd_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  apb3_slv_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready_a), .prdata(prdata_a),
    .pslverr(pslverr_a), .soft_rst(soft_rst), .if_soft_rst(isr_a), .if_req_vld(req_a),
    .if_wr_en(wen_a), .if_rd_en(ren_a), .if_addr(addr_a), .if_wr_data(wd_a),
    .if_ack_vld(if_ack_vld), .if_rd_data(if_rd_data), .if_err(if_err)
  );

  apb3_slv_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready_b), .prdata(prdata_b),
    .pslverr(pslverr_b), .soft_rst(soft_rst), .if_soft_rst(isr_b), .if_req_vld(req_b),
    .if_wr_en(wen_b), .if_rd_en(ren_b), .if_addr(addr_b), .if_wr_data(wd_b),
    .if_ack_vld(if_ack_vld), .if_rd_data(if_rd_data), .if_err(if_err)
  );

  typedef struct {
    logic        sel, en, wr;
    logic [31:0] addr, wdata;
    logic        srst, ack, err;
    logic [31:0] rdata;
    logic        rdy, perr, req, wen, ren;
    logic [31:0] prdata;
    logic        isr;
    logic        chk_cap;
  } vec_t;

  vec_t vq[$];

  // apb = {psel,penable,pwrite}; ctl = {soft_rst,ack,err}; ex = {pready,pslverr,req,wr_en,rd_en}
  function automatic vec_t v(input logic [2:0] apb, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [2:0] ctl,
                             input logic [31:0] rd, input logic [4:0] ex,
                             input logic [31:0] eprd, input logic isr, input logic chk);
    vec_t r;
    {r.sel, r.en, r.wr}                 = apb;
    r.addr                              = addr;
    r.wdata                             = wd;
    {r.srst, r.ack, r.err}              = ctl;
    r.rdata                             = rd;
    {r.rdy, r.perr, r.req, r.wen, r.ren} = ex;
    r.prdata                            = eprd;
    r.isr                               = isr;
    r.chk_cap                           = chk;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic s, input logic e, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic sr, input logic ak,
                     input logic [31:0] rd, input logic er);
    @(posedge clk);
    #1;
    psel = s; penable = e; pwrite = w; paddr = a; pwdata = d;
    soft_rst = sr; if_ack_vld = ak; if_rd_data = rd; if_err = er;
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    soft_rst = 1'b0; if_ack_vld = 1'b0; if_rd_data = '0; if_err = 1'b0;

    // Write 0x10: req at T+1, ack at T+2, pready at T+3.
    vq.push_back(v(3'b101, 'h10, 'hA5A50001, 3'b000, 0,      5'b00000, 0, 0, 0));
    vq.push_back(v(3'b111, 'h10, 'hA5A50001, 3'b000, 0,      5'b00110, 0, 0, 1));
    vq.push_back(v(3'b111, 'h10, 'hA5A50001, 3'b010, 'h1234, 5'b00010, 0, 0, 0));
    vq.push_back(v(3'b111, 'h10, 'hA5A50001, 3'b000, 0,      5'b10010, 0, 0, 0));
    vq.push_back(v(3'b000, 0,    0,          3'b000, 0,      5'b00000, 0, 0, 0));
    // Read 0x20, ack 5 cycles after req: pready at T+7 with data.
    vq.push_back(v(3'b100, 'h20, 0, 3'b000, 0,           5'b00000, 0, 0, 0));
    vq.push_back(v(3'b110, 'h20, 0, 3'b000, 0,           5'b00101, 0, 0, 1));
    for (int k = 0; k < 4; k++)
      vq.push_back(v(3'b110, 'h20, 0, 3'b000, 0,         5'b00001, 0, 0, 0));
    vq.push_back(v(3'b110, 'h20, 0, 3'b010, 'hDEADBEEF,  5'b00001, 0, 0, 0));
    vq.push_back(v(3'b110, 'h20, 0, 3'b000, 0,           5'b10001, 'hDEADBEEF, 0, 0));
    vq.push_back(v(3'b000, 0,    0, 3'b000, 0,           5'b00000, 0, 0, 0));
    // Read 0x30 with slave error.
    vq.push_back(v(3'b100, 'h30, 0, 3'b000, 0, 5'b00000, 0, 0, 0));
    vq.push_back(v(3'b110, 'h30, 0, 3'b000, 0, 5'b00101, 0, 0, 0));
    vq.push_back(v(3'b110, 'h30, 0, 3'b011, 0, 5'b00001, 0, 0, 0));
    vq.push_back(v(3'b110, 'h30, 0, 3'b000, 0, 5'b11001, 0, 0, 0));
    vq.push_back(v(3'b000, 0,    0, 3'b000, 0, 5'b00000, 0, 0, 0));
    // soft_rst in REQ: no req pulse, error response next cycle.
    vq.push_back(v(3'b101, 'h40, 'h55, 3'b000, 0, 5'b00000, 0, 0, 0));
    vq.push_back(v(3'b111, 'h40, 'h55, 3'b100, 0, 5'b00010, 0, 1, 0));
    vq.push_back(v(3'b111, 'h40, 'h55, 3'b000, 0, 5'b11010, 0, 0, 0));
    vq.push_back(v(3'b000, 0,    0,    3'b000, 0, 5'b00000, 0, 0, 0));
    // soft_rst together with ack in WAIT_ACK: error wins, data dropped.
    vq.push_back(v(3'b100, 'h50, 0, 3'b000, 0,          5'b00000, 0, 0, 0));
    vq.push_back(v(3'b110, 'h50, 0, 3'b000, 0,          5'b00101, 0, 0, 0));
    vq.push_back(v(3'b110, 'h50, 0, 3'b110, 'h11112222, 5'b00001, 0, 1, 0));
    vq.push_back(v(3'b110, 'h50, 0, 3'b000, 0,          5'b11001, 0, 0, 0));
    vq.push_back(v(3'b000, 0,    0, 3'b000, 0,          5'b00000, 0, 0, 0));
    // Back-to-back writes: second setup right after the first RESP.
    vq.push_back(v(3'b101, 'h60, 'h6, 3'b000, 0, 5'b00000, 0, 0, 0));
    vq.push_back(v(3'b111, 'h60, 'h6, 3'b000, 0, 5'b00110, 0, 0, 1));
    vq.push_back(v(3'b111, 'h60, 'h6, 3'b010, 0, 5'b00010, 0, 0, 0));
    vq.push_back(v(3'b111, 'h60, 'h6, 3'b000, 0, 5'b10010, 0, 0, 0));
    vq.push_back(v(3'b101, 'h64, 'h7, 3'b000, 0, 5'b00000, 0, 0, 0));
    vq.push_back(v(3'b111, 'h64, 'h7, 3'b000, 0, 5'b00110, 0, 0, 1));
    vq.push_back(v(3'b111, 'h64, 'h7, 3'b011, 0, 5'b00010, 0, 0, 0));
    vq.push_back(v(3'b111, 'h64, 'h7, 3'b000, 0, 5'b11010, 0, 0, 0));
    vq.push_back(v(3'b000, 0,    0,   3'b000, 0, 5'b00000, 0, 0, 0));
    // Stray ack in IDLE is ignored.
    vq.push_back(v(3'b000, 0, 0, 3'b011, 'hFFFFFFFF, 5'b00000, 0, 0, 0));
    vq.push_back(v(3'b000, 0, 0, 3'b000, 0,          5'b00000, 0, 0, 0));
    // psel dropped after setup: transfer still completes.
    vq.push_back(v(3'b100, 'h70, 0, 3'b000, 0,          5'b00000, 0, 0, 0));
    vq.push_back(v(3'b000, 0,    0, 3'b000, 0,          5'b00101, 0, 0, 0));
    vq.push_back(v(3'b000, 0,    0, 3'b010, 'hCAFE0001, 5'b00001, 0, 0, 0));
    vq.push_back(v(3'b000, 0,    0, 3'b000, 0,          5'b10001, 'hCAFE0001, 0, 0));
    vq.push_back(v(3'b000, 0,    0, 3'b000, 0,          5'b00000, 0, 0, 0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset pready", {31'b0, pready_a}, 0);
    check("reset prdata", prdata_a, 0);
    check("reset pslverr", {31'b0, pslverr_a}, 0);
    check("reset if_wr_en", {31'b0, wen_a}, 0);
    check("reset if_rd_en", {31'b0, ren_a}, 0);
    check("reset if_addr", addr_a, 0);
    check("reset if_wr_data", wd_a, 0);
    check("reset if_soft_rst", {31'b0, isr_a}, 0);

    foreach (vq[i]) begin
      cyc(vq[i].sel, vq[i].en, vq[i].wr, vq[i].addr, vq[i].wdata,
          vq[i].srst, vq[i].ack, vq[i].rdata, vq[i].err);
      check($sformatf("row%0d pready", i),      {31'b0, pready_a},  {31'b0, vq[i].rdy});
      check($sformatf("row%0d pslverr", i),     {31'b0, pslverr_a}, {31'b0, vq[i].perr});
      check($sformatf("row%0d prdata", i),      prdata_a,           vq[i].prdata);
      check($sformatf("row%0d if_req_vld", i),  {31'b0, req_a},     {31'b0, vq[i].req});
      check($sformatf("row%0d if_wr_en", i),    {31'b0, wen_a},     {31'b0, vq[i].wen});
      check($sformatf("row%0d if_rd_en", i),    {31'b0, ren_a},     {31'b0, vq[i].ren});
      check($sformatf("row%0d if_soft_rst", i), {31'b0, isr_a},     {31'b0, vq[i].isr});
      if (vq[i].chk_cap) begin
        check($sformatf("row%0d if_addr", i),    addr_a, vq[i].addr);
        check($sformatf("row%0d if_wr_data", i), wd_a,   vq[i].wdata);
      end
    end

    // Timeout on dut_b (4 wait cycles): setup at T, error response at T+6.
    cyc(1'b1, 1'b0, 1'b0, 32'h80, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);   // T
    cyc(1'b1, 1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);   // T+1
    check("to req_vld T+1", {31'b0, req_b}, 1);
    for (int k = 2; k <= 5; k++)
      cyc(1'b1, 1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("to pready T+5", {31'b0, pready_b}, 0);
    check("to if_soft_rst T+5", {31'b0, isr_b}, 0);
    cyc(1'b1, 1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);   // T+6
    check("to pready T+6", {31'b0, pready_b}, 1);
    check("to pslverr T+6", {31'b0, pslverr_b}, 1);
    check("to prdata T+6", prdata_b, 0);
    check("to if_soft_rst T+6", {31'b0, isr_b}, 1);
    check("no-timeout inst pready T+6", {31'b0, pready_a}, 0);
    check("no-timeout inst soft_rst T+6", {31'b0, isr_a}, 0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h99, 1'b0);   // T+7 late ack
    check("to pready T+7", {31'b0, pready_b}, 0);
    check("to if_soft_rst T+7", {31'b0, isr_b}, 0);
    check("to if_rd_en T+7", {31'b0, ren_b}, 0);
    idle();                                                           // T+8
    check("late ack pready", {31'b0, pready_b}, 0);
    check("late ack pslverr", {31'b0, pslverr_b}, 0);
    check("late ack req_vld", {31'b0, req_b}, 0);
    check("no-timeout inst pready T+8", {31'b0, pready_a}, 1);
    check("no-timeout inst prdata T+8", prdata_a, 32'h99);
    idle();                                                           // T+9
    check("late ack pready T+9", {31'b0, pready_b}, 0);

    // Async reset in the middle of WAIT_ACK.
    cyc(1'b1, 1'b0, 1'b1, 32'h90, 32'h12345678, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 32'h90, 32'h12345678, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 32'h90, 32'h12345678, 1'b0, 1'b0, 32'h0, 1'b0);
    check("pre-reset if_wr_en", {31'b0, wen_a}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst pready", {31'b0, pready_a}, 0);
    check("async rst if_wr_en", {31'b0, wen_a}, 0);
    check("async rst if_addr", addr_a, 0);
    check("async rst if_wr_data", wd_a, 0);
    check("async rst if_req_vld", {31'b0, req_a}, 0);
    check("async rst dut_b if_wr_en", {31'b0, wen_b}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    check("post rst pready", {31'b0, pready_a}, 0);
    check("post rst pslverr", {31'b0, pslverr_a}, 0);
    check("post rst prdata", prdata_a, 0);
    // Fresh read after reset must run the normal sequence from IDLE.
    cyc(1'b1, 1'b0, 1'b0, 32'hA0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("post rst setup req_vld", {31'b0, req_a}, 0);
    cyc(1'b1, 1'b1, 1'b0, 32'hA0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("post rst req_vld", {31'b0, req_a}, 1);
    check("post rst if_addr", addr_a, 32'hA0);
    cyc(1'b1, 1'b1, 1'b0, 32'hA0, 32'h0, 1'b0, 1'b1, 32'h5A5A, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 32'hA0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("post rst pready", {31'b0, pready_a}, 1);
    check("post rst read data", prdata_a, 32'h5A5A);
    idle();
    check("post rst pready clear", {31'b0, pready_a}, 0);
    check("post rst prdata clear", prdata_a, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
